mul_seq_qfmt: RTL and testbench
===============================

Name: mul_seq_qfmt

Overview:
- Parametrised sequential signed shift-add multiplier for the MHA datapath; the next generation of the 16-bit pipeline multiplier.
- Generic width `D_W` and fractional-bit count `FRAC_W`.
- Adds selectable rounding and saturation, an overflow flag, the full-precision product, and a valid/ready output handshake that allows back-to-back operations.
- Used by the attention score/scaling paths wherever a DSP-free Q-format multiply is needed.

Parameters:
- `D_W`, 16, operand and Q-result width in bits; two's complement; legal range 4..32.
- `FRAC_W`, 13, fractional bits of operands and result (16 gives Q2.13; 8 with `FRAC_W`=5 gives Q2.5); legal range 0..D_W-1.

Ports:
- `I_CLK`  in  1  clock; all logic on rising edge.
- `I_RST`  in  1  synchronous active-high reset.
- `I_VLD`  in  1  operand valid.
- `O_RDY`  out  1  block can accept operands this cycle.
- `I_M1`  in  D_W  multiplicand, signed Q-format.
- `I_M2`  in  D_W  multiplier, signed Q-format.
- `I_MODE`  in  2  bit0 = round half-up (0 = truncate/floor); bit1 = saturate (0 = wrap). Latched at accept.
- `O_VLD`  out  1  result valid; held until consumed.
- `I_RDY`  in  1  downstream ready.
- `O_BUSY`  out  1  state != IDLE.
- `O_PRODUCT`  out  D_W  rounded/saturated Q-format result.
- `O_FULL`  out  2*D_W  exact signed product M1*M2 (2*FRAC_W fractional bits).
- `O_OVF`  out  1  result did not fit in D_W signed, in either saturate or wrap mode.

Behaviour:
- Reset: one synchronous cycle with `I_RST`=1 forces state IDLE, all registers 0. Outputs after reset: `O_VLD`=0, `O_BUSY`=0, `O_PRODUCT`=0, `O_FULL`=0, `O_OVF`=0, `O_RDY`=1. Reset mid-operation aborts with no `O_VLD` pulse.
- Accept: occurs on an edge where `I_VLD` & `O_RDY`. Latches `M1` sign-extended to 2*D_W, `M2`, and `I_MODE`. Clears the accumulator and cycle counter (width `$clog2(D_W)`).
- `O_RDY` is 1 in IDLE, equals `I_RDY` in DONE, and is 0 in CALC/FIX.
- States:
  - IDLE -> CALC on accept.
  - CALC, D_W-1 cycles: at step i (0..D_W-2), acc += (M1<<i) if M2[i].
  - CALC -> FIX when counter == D_W-2.
  - FIX, 1 cycle: acc -= (M1<<(D_W-1)) if M2[D_W-1] (sign-bit weight); compute the Q result; register `O_FULL`, `O_PRODUCT`, `O_OVF`; FIX -> DONE.
  - DONE: `O_VLD`=1 and outputs stable.
    - `I_RDY`=1 and `I_VLD`=0: -> IDLE.
    - `I_RDY`=1 and `I_VLD`=1: accept in the same cycle, -> CALC.
    - `I_RDY`=0: stay in DONE, outputs held.
- Latency: `O_VLD` rises D_W+1 edges after the accept edge (17 for D_W=16). Throughput is one result per D_W+1 cycles when `I_RDY` is held at 1.
- Q conversion, computed at 2*D_W+1 bits:
  - t = acc + (round ? 2^(FRAC_W-1) : 0); no add when `FRAC_W`=0.
  - r = t >>> FRAC_W (arithmetic shift).
  - fits = r within [-2^(D_W-1), 2^(D_W-1)-1]; `O_OVF` = !fits.
  - Saturate mode: clamp to 0x7FFF/0x8000 (D_W=16).
  - Wrap mode: take r[D_W-1:0].
- Boundaries:
  - min*min (e.g. 0x8000*0x8000) gives the exact `O_FULL` 0x40000000 and overflows the Q range.
  - Rounding carry past the maximum is caught by the overflow check.
  - Zero operands take the full latency; there is no early termination.
  - Operand and mode inputs are ignored while not `O_RDY`.

Decomposition:
- Shared package `mha_mul_pkg`:
  - state enum IDLE/CALC/FIX/DONE;
  - `MODE_RND`=0 and `MODE_SAT`=1 bit indices;
  - helper constants for the Q max/min as a function of D_W.
- One combinational sub-module `mul_qfmt_round_sat`: inputs acc (2*D_W), mode; outputs Q result and ovf. It is reused by future MAC blocks.
- The FSM, counter and accumulator remain in the top module.

Test Plan:
- D_W=16, FRAC_W=13, mode=00, M1=0x2000 (1.0), M2=0x2000 -> 17 cycles after accept: `O_VLD`=1, `O_PRODUCT`=0x2000, `O_FULL`=0x04000000, `O_OVF`=0.
- M1=0xE000 (-1.0), M2=0x2000 -> `O_PRODUCT`=0xE000.
- M1=0x4000, M2=0x4000 (2.0*2.0):
  - mode=10 -> 0x7FFF, `O_OVF`=1.
  - mode=00 -> 0x8000, `O_OVF`=1.
  - Also M1=M2=0x8000 with mode=10 -> 0x7FFF, `O_FULL`=0x40000000.
- Rounding, M1=0x0001, M2=0x1000:
  - mode=00 -> 0x0000; mode=01 -> 0x0001.
  - With M1=0xFFFF: mode=00 -> 0xFFFF; mode=01 -> 0x0000.
- Handshake:
  - Hold `I_RDY`=0 for 5 cycles in DONE -> `O_VLD`/outputs stable and `O_RDY`=0.
  - Then `I_RDY`=1 with `I_VLD`=1 -> new operands accepted that cycle; next `O_VLD` 17 cycles later.
  - Random back-to-back stream of 1000 operations checked against a reference model.
- Assert `I_RST` at CALC step 7 -> next cycle IDLE, `O_BUSY`=0, all outputs 0, no `O_VLD`. Repeat the directed cases with D_W=8, FRAC_W=5: 0x20*0x20 -> 0x20.

Source files
------------

// File: rtl/mha_mul_pkg.sv
// rtl/mha_mul_pkg.sv - shared state, mode-bit and Q-range definitions for the MHA multipliers
package mha_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  localparam int MODE_RND = 0;
  localparam int MODE_SAT = 1;

  function automatic longint q_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint q_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/mul_qfmt_round_sat.sv
// rtl/mul_qfmt_round_sat.sv - full-precision product to D_W-bit Q result with round/saturate
module mul_qfmt_round_sat
  import mha_mul_pkg::*;
#(
  parameter int D_W    = 16,
  parameter int FRAC_W = 13
) (
  input  logic [2*D_W-1:0] acc,
  input  logic [1:0]       mode,
  output logic [D_W-1:0]   q,
  output logic             ovf
);

  // One guard bit above the product so the rounding add can never wrap.
  localparam int XW = 2 * D_W + 1;
  localparam logic signed [XW-1:0] R_MAX = XW'(q_max(D_W));
  localparam logic signed [XW-1:0] R_MIN = XW'(q_min(D_W));
  localparam logic signed [XW-1:0] HALF  =
    (FRAC_W > 0) ? (XW'(1) <<< ((FRAC_W > 0) ? FRAC_W - 1 : 0)) : '0;

  logic signed [XW-1:0] t;
  logic signed [XW-1:0] r;
  logic                 fits;

  always_comb begin
    t = XW'($signed(acc));
    if (mode[MODE_RND]) begin
      t = t + HALF;
    end
    r    = t >>> FRAC_W;
    fits = (r <= R_MAX) && (r >= R_MIN);
    ovf  = !fits;
    if (!fits && mode[MODE_SAT]) begin
      q = r[XW-1] ? R_MIN[D_W-1:0] : R_MAX[D_W-1:0];
    end else begin
      q = r[D_W-1:0];
    end
  end

endmodule

// File: rtl/mul_seq_qfmt.sv
// rtl/mul_seq_qfmt.sv - sequential signed shift-add Q-format multiplier with valid/ready output
module mul_seq_qfmt
  import mha_mul_pkg::*;
#(
  parameter int D_W    = 16,
  parameter int FRAC_W = 13
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_VLD,
  output logic             O_RDY,
  input  logic [D_W-1:0]   I_M1,
  input  logic [D_W-1:0]   I_M2,
  input  logic [1:0]       I_MODE,
  output logic             O_VLD,
  input  logic             I_RDY,
  output logic             O_BUSY,
  output logic [D_W-1:0]   O_PRODUCT,
  output logic [2*D_W-1:0] O_FULL,
  output logic             O_OVF
);

  localparam int PW = 2 * D_W;
  localparam int CW = $clog2(D_W);
  localparam logic [CW-1:0] LAST_STEP = CW'(D_W - 2);

  mul_state_e    state;
  mul_state_e    state_nxt;
  logic [PW-1:0] m1_ext;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_fix;
  logic [PW-1:0] full_q;
  logic [D_W-1:0] m2_q;
  logic [D_W-1:0] prod_q;
  logic [D_W-1:0] q_res;
  logic [1:0]    mode_q;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic          q_ovf;
  logic          accept;

  assign accept = I_VLD && O_RDY;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == LAST_STEP) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (I_RDY) state_nxt = I_VLD ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    O_RDY = 1'b0;
    case (state)
      IDLE:    O_RDY = 1'b1;
      DONE:    O_RDY = I_RDY;
      default: O_RDY = 1'b0;
    endcase
    O_VLD  = (state == DONE);
    O_BUSY = (state != IDLE);
  end

  // The multiplier MSB carries negative weight, so the last partial product is subtracted.
  assign acc_fix = m2_q[D_W-1] ? (acc - (m1_ext << (D_W - 1))) : acc;

  mul_qfmt_round_sat #(
    .D_W   (D_W),
    .FRAC_W(FRAC_W)
  ) u_round_sat (
    .acc (acc_fix),
    .mode(mode_q),
    .q   (q_res),
    .ovf (q_ovf)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      m1_ext <= '0;
      m2_q   <= '0;
      mode_q <= '0;
      acc    <= '0;
      cnt    <= '0;
      full_q <= '0;
      prod_q <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      m1_ext <= PW'($signed(I_M1));
      m2_q   <= I_M2;
      mode_q <= I_MODE;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      if (m2_q[cnt]) begin
        acc <= acc + (m1_ext << cnt);
      end
      cnt <= cnt + CW'(1);
    end else if (state == FIX) begin
      full_q <= acc_fix;
      prod_q <= q_res;
      ovf_q  <= q_ovf;
    end
  end

  assign O_PRODUCT = prod_q;
  assign O_FULL    = full_q;
  assign O_OVF     = ovf_q;

endmodule

// File: tb/tb_mul_seq_qfmt.sv
// tb/tb_mul_seq_qfmt.sv - self-checking bench for mul_seq_qfmt at D_W=16/FRAC_W=13 and D_W=8/FRAC_W=5
module tb_mul_seq_qfmt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        vld_a, rdy_a, ordy_a, ovld_a, busy_a, ovf_a;
  logic [15:0] m1_a, m2_a, prod_a;
  logic [1:0]  mode_a;
  logic [31:0] full_a;

  logic        vld_b, rdy_b, ordy_b, ovld_b, busy_b, ovf_b;
  logic [7:0]  m1_b, m2_b, prod_b;
  logic [1:0]  mode_b;
  logic [15:0] full_b;

  mul_seq_qfmt #(.D_W(16), .FRAC_W(13)) dut_a (
    .I_CLK(clk), .I_RST(rst), .I_VLD(vld_a), .O_RDY(ordy_a),
    .I_M1(m1_a), .I_M2(m2_a), .I_MODE(mode_a), .O_VLD(ovld_a),
    .I_RDY(rdy_a), .O_BUSY(busy_a), .O_PRODUCT(prod_a),
    .O_FULL(full_a), .O_OVF(ovf_a)
  );

  mul_seq_qfmt #(.D_W(8), .FRAC_W(5)) dut_b (
    .I_CLK(clk), .I_RST(rst), .I_VLD(vld_b), .O_RDY(ordy_b),
    .I_M1(m1_b), .I_M2(m2_b), .I_MODE(mode_b), .O_VLD(ovld_b),
    .I_RDY(rdy_b), .O_BUSY(busy_b), .O_PRODUCT(prod_b),
    .O_FULL(full_b), .O_OVF(ovf_b)
  );

  typedef struct {
    logic [63:0] full;
    logic [31:0] prod;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        ordy;
    logic        ovld;
    logic        busy;
    logic        ovf;
    logic [31:0] prod;
    logic [63:0] full;
  } obs_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int dw, input int fw, input logic [31:0] a,
                                 input logic [31:0] b, input logic [1:0] md);
    longint mask, sa, sbv, p, t, r, mx, mn, q;
    exp_t   e;
    mask = (longint'(1) << dw) - 1;
    sa   = longint'({32'h0, a}) & mask;
    sbv  = longint'({32'h0, b}) & mask;
    if (sa[dw-1])  sa  = sa  - (longint'(1) << dw);
    if (sbv[dw-1]) sbv = sbv - (longint'(1) << dw);
    p = sa * sbv;
    t = p;
    if (md[0] && fw > 0) t = t + (longint'(1) << (fw - 1));
    r  = t >>> fw;
    mx = (longint'(1) << (dw - 1)) - 1;
    mn = -mx - 1;
    e.ovf  = (r > mx) || (r < mn);
    q      = (e.ovf && md[1]) ? ((r < 0) ? mn : mx) : r;
    e.prod = 32'(q & mask);
    e.full = 64'(p) & 64'((longint'(1) << (2 * dw)) - 1);
    return e;
  endfunction

  function automatic obs_t snap(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.ordy = ordy_a; o.ovld = ovld_a; o.busy = busy_a; o.ovf = ovf_a;
      o.prod = {16'h0, prod_a}; o.full = {32'h0, full_a};
    end else begin
      o.ordy = ordy_b; o.ovld = ovld_b; o.busy = busy_b; o.ovf = ovf_b;
      o.prod = {24'h0, prod_b}; o.full = {48'h0, full_b};
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] md);
    if (sel == 0) begin
      vld_a = v; m1_a = a[15:0]; m2_a = b[15:0]; mode_a = md;
    end else begin
      vld_b = v; m1_b = a[7:0]; m2_b = b[7:0]; mode_b = md;
    end
  endtask

  task automatic push_cur(input int sel);
    if (sel == 0) sb_a.push_back(model(16, 13, {16'h0, m1_a}, {16'h0, m2_a}, mode_a));
    else          sb_b.push_back(model(8, 5, {24'h0, m1_b}, {24'h0, m2_b}, mode_b));
  endtask

  task automatic check_sb(input int sel, input obs_t o);
    exp_t e;
    int   depth;
    depth = (sel == 0) ? sb_a.size() : sb_b.size();
    chk("sb_nonempty", 64'(depth != 0), 64'd1);
    if (depth != 0) begin
      e = (sel == 0) ? sb_a.pop_front() : sb_b.pop_front();
      chk("sb_prod", 64'(o.prod), 64'(e.prod));
      chk("sb_full", o.full, e.full);
      chk("sb_ovf", 64'(o.ovf), 64'(e.ovf));
    end
  endtask

  // Counts edges from the accept edge (inclusive) until O_VLD is seen; inputs are scrambled while busy.
  task automatic wait_result(input int sel, output int k);
    obs_t o;
    k = 0;
    do begin
      tick();
      k++;
      if (k == 1) drive(sel, 1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
      #1;
      o = snap(sel);
    end while (!o.ovld && k < 60);
  endtask

  task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] md, output obs_t o);
    int k;
    drive(sel, 1'b1, a, b, md);
    #1;
    o = snap(sel);
    chk("accept_rdy", 64'(o.ordy), 64'd1);
    push_cur(sel);
    wait_result(sel, k);
    chk("latency", 64'(k), 64'((sel == 0) ? 17 : 9));
    o = snap(sel);
    check_sb(sel, o);
    tick();
  endtask

  function automatic logic [31:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 32'h8000;
      1:       return 32'h7FFF;
      2:       return 32'h0000;
      default: return 32'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  initial begin
    obs_t o;
    exp_t e;
    int   k;
    int   n_done;
    int   cyc;
    logic seen;

    rst = 1'b1;
    drive(0, 1'b0, 0, 0, 2'b00);
    drive(1, 1'b0, 0, 0, 2'b00);
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    tick();
    tick();
    #1;
    for (int s = 0; s < 2; s++) begin
      o = snap(s);
      chk("rst_vld", 64'(o.ovld), 64'd0);
      chk("rst_busy", 64'(o.busy), 64'd0);
      chk("rst_prod", 64'(o.prod), 64'd0);
      chk("rst_full", o.full, 64'd0);
      chk("rst_ovf", 64'(o.ovf), 64'd0);
      chk("rst_rdy", 64'(o.ordy), 64'd1);
    end
    rst = 1'b0;
    tick();

    do_op(0, 32'h2000, 32'h2000, 2'b00, o);
    chk("one_prod", 64'(o.prod), 64'h2000);
    chk("one_full", o.full, 64'h0400_0000);
    chk("one_ovf", 64'(o.ovf), 64'd0);
    do_op(0, 32'hE000, 32'h2000, 2'b00, o);
    chk("neg_prod", 64'(o.prod), 64'hE000);
    do_op(0, 32'h4000, 32'h4000, 2'b10, o);
    chk("sat_prod", 64'(o.prod), 64'h7FFF);
    chk("sat_ovf", 64'(o.ovf), 64'd1);
    do_op(0, 32'h4000, 32'h4000, 2'b00, o);
    chk("wrap_prod", 64'(o.prod), 64'h8000);
    chk("wrap_ovf", 64'(o.ovf), 64'd1);
    do_op(0, 32'h8000, 32'h8000, 2'b10, o);
    chk("minmin_prod", 64'(o.prod), 64'h7FFF);
    chk("minmin_full", o.full, 64'h4000_0000);
    do_op(0, 32'h0001, 32'h1000, 2'b00, o);
    chk("trunc_pos", 64'(o.prod), 64'h0000);
    do_op(0, 32'h0001, 32'h1000, 2'b01, o);
    chk("round_pos", 64'(o.prod), 64'h0001);
    do_op(0, 32'hFFFF, 32'h1000, 2'b00, o);
    chk("trunc_neg", 64'(o.prod), 64'hFFFF);
    do_op(0, 32'hFFFF, 32'h1000, 2'b01, o);
    chk("round_neg", 64'(o.prod), 64'h0000);
    do_op(0, 32'h0000, 32'h0000, 2'b11, o);
    chk("zero_prod", 64'(o.prod), 64'h0000);
    do_op(0, 32'h7FFF, 32'h7FFF, 2'b11, o);
    chk("maxmax_ovf", 64'(o.ovf), 64'd1);

    do_op(1, 32'h20, 32'h20, 2'b00, o);
    chk("b_one_prod", 64'(o.prod), 64'h20);
    chk("b_one_full", o.full, 64'h0400);
    do_op(1, 32'h40, 32'h40, 2'b10, o);
    chk("b_sat_prod", 64'(o.prod), 64'h7F);
    chk("b_sat_ovf", 64'(o.ovf), 64'd1);
    do_op(1, 32'h80, 32'h80, 2'b00, o);
    chk("b_minmin_full", o.full, 64'h4000);
    chk("b_minmin_prod", 64'(o.prod), 64'h00);
    do_op(1, 32'h01, 32'h10, 2'b01, o);
    chk("b_round_prod", 64'(o.prod), 64'h01);

    rdy_a = 1'b0;
    e = model(16, 13, 32'h3000, 32'h2800, 2'b01);
    drive(0, 1'b1, 32'h3000, 32'h2800, 2'b01);
    #1;
    push_cur(0);
    wait_result(0, k);
    chk("hold_latency", 64'(k), 64'd17);
    repeat (5) begin
      o = snap(0);
      chk("hold_vld", 64'(o.ovld), 64'd1);
      chk("hold_prod", 64'(o.prod), 64'(e.prod));
      chk("hold_full", o.full, e.full);
      chk("hold_rdy", 64'(o.ordy), 64'd0);
      tick();
      #1;
    end
    check_sb(0, snap(0));
    rdy_a = 1'b1;
    drive(0, 1'b1, 32'hC000, 32'h3000, 2'b00);
    #1;
    o = snap(0);
    chk("done_accept_rdy", 64'(o.ordy), 64'd1);
    push_cur(0);
    wait_result(0, k);
    chk("b2b_latency", 64'(k), 64'd17);
    check_sb(0, snap(0));
    tick();

    drive(0, 1'b1, 32'h1234, 32'h5678, 2'b00);
    #1;
    tick();
    drive(0, 1'b0, 0, 0, 2'b00);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    o = snap(0);
    chk("abort_busy", 64'(o.busy), 64'd0);
    chk("abort_vld", 64'(o.ovld), 64'd0);
    chk("abort_prod", 64'(o.prod), 64'd0);
    chk("abort_full", o.full, 64'd0);
    chk("abort_ovf", 64'(o.ovf), 64'd0);
    chk("abort_rdy", 64'(o.ordy), 64'd1);
    seen = 1'b0;
    repeat (25) begin
      tick();
      #1;
      if (ovld_a) seen = 1'b1;
    end
    chk("abort_no_vld", 64'(seen), 64'd0);

    rdy_a  = 1'b1;
    n_done = 0;
    cyc    = 0;
    drive(0, 1'b1, rnd16(), rnd16(), 2'($urandom_range(0, 3)));
    #1;
    while (n_done < 1000 && cyc < 20000) begin
      o = snap(0);
      if (o.ovld) begin
        check_sb(0, o);
        n_done++;
      end
      if (o.ordy && vld_a) push_cur(0);
      tick();
      cyc++;
      drive(0, 1'b1, rnd16(), rnd16(), 2'($urandom_range(0, 3)));
      #1;
    end
    chk("stream_count", 64'(n_done), 64'd1000);
    drive(0, 1'b0, 0, 0, 2'b00);
    k = 0;
    while (!ovld_a && k < 40) begin
      tick();
      #1;
      k++;
    end
    chk("stream_drain_vld", 64'(ovld_a), 64'd1);
    if (ovld_a) check_sb(0, snap(0));
    chk("stream_sb_empty", 64'(sb_a.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
